// File: rtl/sw_debounce_if.sv
// Switch debounce bus: raw levels in, debounced levels and edge pulses out.
//   sw      : raw asynchronous switch levels (driven by the board/master side)
//   sw_db   : debounced, registered levels
//   sw_rise : one-cycle pulse per bit on an accepted 0->1 change
//   sw_fall : one-cycle pulse per bit on an accepted 1->0 change
interface sw_debounce_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] sw;
    logic [N-1:0] sw_db;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;

    modport master (output sw, input sw_db, input sw_rise, input sw_fall);
    modport slave  (input sw, output sw_db, output sw_rise, output sw_fall);
endinterface

// File: rtl/sw_debounce.sv
// Parallel switch debouncer with per-bit synchronizer, settle counter and edge pulses.
//   clk   : system clock, all state updates on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sw_debounce_if slave (sw in; sw_db, sw_rise, sw_fall out, all registered)
// A new level is accepted after DB_CYCLES consecutive synchronized samples
// that differ from the current debounced level.
module sw_debounce #(
    parameter int unsigned N         = 8,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    sw_debounce_if.slave  bus
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_e;

    logic [N-1:0]  s1_q;
    logic [N-1:0]  s2_q;
    logic [N-1:0]  db_q;
    logic [N-1:0]  rise_q;
    logic [N-1:0]  fall_q;
    logic [CW-1:0] cnt_q   [N];

    logic [N-1:0]  db_nxt;
    logic [N-1:0]  rise_nxt;
    logic [N-1:0]  fall_nxt;
    logic [CW-1:0] cnt_nxt [N];
    state_e        state_c [N];

    // State registers: synchronizer, counters, debounced level and pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= bus.sw;
            s2_q   <= s1_q;
            db_q   <= db_nxt;
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= cnt_nxt[i];
            end
        end
    end

    // Per-bit next state: any sample matching the current level restarts the count
    always_comb begin
        db_nxt   = db_q;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt_nxt[i] = cnt_q[i];
            state_c[i] = (cnt_q[i] == '0) ? ST_STABLE : ST_SETTLING;
        end
        for (int i = 0; i < int'(N); i++) begin
            case (state_c[i])
                ST_STABLE: begin
                    if (s2_q[i] != db_q[i]) begin
                        // Only reachable as an immediate accept when DB_CYCLES == 1
                        if (cnt_q[i] == LAST) begin
                            db_nxt[i]   = s2_q[i];
                            rise_nxt[i] = s2_q[i];
                            fall_nxt[i] = ~s2_q[i];
                            cnt_nxt[i]  = '0;
                        end else begin
                            cnt_nxt[i] = CW'(1);
                        end
                    end
                end
                ST_SETTLING: begin
                    if (s2_q[i] == db_q[i]) begin
                        cnt_nxt[i] = '0;
                    end else if (cnt_q[i] == LAST) begin
                        db_nxt[i]   = s2_q[i];
                        rise_nxt[i] = s2_q[i];
                        fall_nxt[i] = ~s2_q[i];
                        cnt_nxt[i]  = '0;
                    end else begin
                        cnt_nxt[i] = cnt_q[i] + CW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.sw_db   = db_q;
    assign bus.sw_rise = rise_q;
    assign bus.sw_fall = fall_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce (N=8, DB_CYCLES=4): table vectors, corner sequences
// and randomized stimulus against a sample-history reference model.
module tb_sw_debounce;

    localparam int unsigned N  = 8;
    localparam int unsigned DB = 4;

    typedef struct packed {
        logic [N-1:0] sw;
        logic [N-1:0] db;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } vec_t;

    logic clk;
    logic rst_n;

    sw_debounce_if #(.N(N)) bus ();

    sw_debounce #(.N(N), .DB_CYCLES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: history of raw samples taken at each rising edge.
    // The debounce decision at edge k sees the sample from edge k-2, so a level
    // is accepted at edge k when samples k-DB-1 .. k-2 all differ from m_db.
    logic [N-1:0] hist [$];
    logic [N-1:0] m_db;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_fall;

    vec_t tbl [24];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        for (int j = 0; j < int'(DB) + 2; j++) hist.push_back('0);
        m_db   = '0;
        m_rise = '0;
        m_fall = '0;
    endtask

    // One clock: advance the model at the edge, then compare #1 later
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            hist.push_back(bus.sw);
            void'(hist.pop_front());
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < int'(N); b++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int j = 0; j < int'(DB); j++) begin
                    if (hist[j][b] == m_db[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_db[b]   = ~m_db[b];
                    m_rise[b] = m_db[b];
                    m_fall[b] = ~m_db[b];
                end
            end
        end
        #1;
        chk("model_db",   bus.sw_db,   m_db);
        chk("model_rise", bus.sw_rise, m_rise);
        chk("model_fall", bus.sw_fall, m_fall);
        if ((bus.sw_rise & bus.sw_fall) != '0) begin
            miscompares++;
            $display("FAIL rise_and_fall_same_bit: rise %h fall %h", bus.sw_rise, bus.sw_fall);
        end
    endtask

    task automatic pulse_reset(input int cycles);
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("async_rst_db",   bus.sw_db,   '0);
        chk("async_rst_rise", bus.sw_rise, '0);
        chk("async_rst_fall", bus.sw_fall, '0);
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset release with all switches high, falling release, then clean press
        for (int i = 0; i < 7; i++) begin
            tbl[i].sw   = 8'hFF;
            tbl[i].db   = (i >= 5) ? 8'hFF : 8'h00;
            tbl[i].rise = (i == 5) ? 8'hFF : 8'h00;
            tbl[i].fall = 8'h00;
        end
        for (int i = 0; i < 7; i++) begin
            tbl[7+i].sw   = 8'h00;
            tbl[7+i].db   = (i >= 5) ? 8'h00 : 8'hFF;
            tbl[7+i].rise = 8'h00;
            tbl[7+i].fall = (i == 5) ? 8'hFF : 8'h00;
        end
        for (int i = 0; i < 10; i++) begin
            tbl[14+i].sw   = 8'h01;
            tbl[14+i].db   = (i >= 5) ? 8'h01 : 8'h00;
            tbl[14+i].rise = (i == 5) ? 8'h01 : 8'h00;
            tbl[14+i].fall = 8'h00;
        end

        rst_n  = 1'b0;
        bus.sw = '0;
        model_clear();
        #1;
        chk("reset_db",   bus.sw_db,   8'h00);
        chk("reset_rise", bus.sw_rise, 8'h00);
        chk("reset_fall", bus.sw_fall, 8'h00);
        bus.sw = 8'hFF;
        repeat (3) tick();
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            bus.sw = tbl[i].sw;
            tick();
            chk($sformatf("tbl%0d_db", i),   bus.sw_db,   tbl[i].db);
            chk($sformatf("tbl%0d_rise", i), bus.sw_rise, tbl[i].rise);
            chk($sformatf("tbl%0d_fall", i), bus.sw_fall, tbl[i].fall);
        end

        // Bounce on bit 3: 2-cycle toggles for 20 cycles, then held high
        for (int c = 0; c < 30; c++) begin
            logic b3;
            b3 = (c >= 20) ? 1'b1 : (((c >> 1) & 1) == 0);
            bus.sw = 8'h01 | {4'b0, b3, 3'b0};
            tick();
            chk("bounce_db",   bus.sw_db,   (c >= 25) ? 8'h09 : 8'h01);
            chk("bounce_rise", bus.sw_rise, (c == 25) ? 8'h08 : 8'h00);
        end

        // Three-cycle glitch on bit 5 must be rejected
        for (int c = 0; c < 10; c++) begin
            bus.sw = (c < 3) ? 8'h29 : 8'h09;
            tick();
            chk("glitch_db",   bus.sw_db,   8'h09);
            chk("glitch_rise", bus.sw_rise, 8'h00);
            chk("glitch_fall", bus.sw_fall, 8'h00);
        end

        // Simultaneous rise on bit 1 and fall on bit 2
        bus.sw = 8'h0D;
        repeat (6) tick();
        for (int c = 0; c < 7; c++) begin
            bus.sw = 8'h0B;
            tick();
            chk("simul_db",   bus.sw_db,   (c >= 5) ? 8'h0B : 8'h0D);
            chk("simul_rise", bus.sw_rise, (c == 5) ? 8'h02 : 8'h00);
            chk("simul_fall", bus.sw_fall, (c == 5) ? 8'h04 : 8'h00);
        end

        // Reset while bit 4 is settling; full latency counted from release
        bus.sw = 8'h1B;
        repeat (2) tick();
        pulse_reset(2);
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("rstmid_db",   bus.sw_db,   (c >= 5) ? 8'h1B : 8'h00);
            chk("rstmid_rise", bus.sw_rise, (c == 5) ? 8'h1B : 8'h00);
        end

        // Randomized per-bit toggling with occasional resets
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] flip;
            for (int b = 0; b < int'(N); b++) flip[b] = ($urandom_range(0, 5) == 0);
            bus.sw = bus.sw ^ flip;
            if ($urandom_range(0, 299) == 0) pulse_reset(1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the number of switch inputs debounced in parallel.
REQ-002 The block SHALL have parameter DB_CYCLES, default 1000000, meaning consecutive stable clk cycles required to accept a new level (10 ms at 100 MHz); legal range 1 to 2^24-1.
REQ-003 The block SHALL have port clk, input, width 1: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port sw, input, width N: raw asynchronous switch levels from board pins.
REQ-006 The block SHALL have port sw_db, output, width N: debounced switch levels, registered, to be fed directly to the LED blink stage's sw input.
REQ-007 The block SHALL have port sw_rise, output, width N: one-cycle pulse per bit when sw_db[i] goes 0->1.
REQ-008 The block SHALL have port sw_fall, output, width N: one-cycle pulse per bit when sw_db[i] goes 1->0.

Function
REQ-009 Each sw[i] SHALL pass through a two-flop synchronizer (s1, s2); only s2[i] is used by the debounce logic.
REQ-010 Each bit SHALL have an independent counter cnt[i] of width clog2(DB_CYCLES+1); bits never share state.
REQ-011 Per-bit state machine: STABLE (cnt[i]==0) and SETTLING (cnt[i]!=0).
REQ-012 At each edge where s2[i]==sw_db[i], cnt[i] SHALL become 0 (SETTLING->STABLE abort; no output change).
REQ-013 At each edge where s2[i]!=sw_db[i] and cnt[i]<DB_CYCLES-1, cnt[i] SHALL increment by 1 (STABLE->SETTLING or stay SETTLING).
REQ-014 At each edge where s2[i]!=sw_db[i] and cnt[i]==DB_CYCLES-1, sw_db[i] SHALL take s2[i], cnt[i] SHALL become 0, and exactly one of sw_rise[i]/sw_fall[i] SHALL be 1 for that one cycle, matching the new level.
REQ-015 sw_rise and sw_fall SHALL be registered and 0 in every cycle not covered by REQ-014; they are never both 1 for the same bit.
REQ-016 Latency: sw[i] changed and held before edge E0 SHALL produce the sw_db[i] update and pulse after edge E0+DB_CYCLES+1; no earlier, no later.
REQ-017 Any return of s2[i] to sw_db[i] before acceptance SHALL restart the full DB_CYCLES count (no partial credit).
REQ-018 With DB_CYCLES=1 the block SHALL degenerate to a 2-flop synchronizer plus one register stage with edge pulses.
REQ-019 Counter SHALL never exceed DB_CYCLES-1; no wrap-around is reachable.
REQ-020 Simultaneous acceptance on multiple bits in the same cycle SHALL update and pulse all such bits in that cycle.

Reset
REQ-021 While rst_n=0, s1, s2, sw_db, sw_rise, sw_fall and all cnt SHALL be 0, asynchronously and independent of clk.
REQ-022 Reset asserted mid-settling SHALL discard the count; after release, any bit with sw[i]=1 SHALL be accepted as a normal 0->1 change per REQ-016 with an sw_rise pulse.
REQ-023 Reset release SHALL be assumed synchronized externally to clk; no reset-release glitch filtering in this block.

Verification (bench uses N=8, DB_CYCLES=4)
REQ-024 Reset: sw=8'hFF held, rst_n 0->1 before edge E0 -> sw_db=8'h00 until after edge E0+5, then 8'hFF with sw_rise=8'hFF for exactly one cycle.
REQ-025 Clean press: sw[0] 0->1 before edge E0, held 10 cycles -> sw_db[0]=1 and sw_rise[0]=1 after E0+5; sw_rise[0]=0 after E0+6; other bits unchanged.
REQ-026 Bounce: sw[3] toggles every 2 cycles for 20 cycles then holds 1 -> no change on sw_db[3] during bounce; single sw_rise[3] pulse 5 edges after last transition.
REQ-027 Glitch: sw[5] high for 3 cycles only -> sw_db[5] stays 0, no pulses.
REQ-028 Simultaneous: sw[1] 0->1 and sw[2] 1->0 before the same edge -> sw_rise[1] and sw_fall[2] pulse in the same cycle.
REQ-029 Reset mid-settling: sw[4] 0->1, rst_n pulsed low 2 cycles later -> sw_db[4]=0 during reset; after release, acceptance occurs at full latency per REQ-016 from release.
